psum_deskew_drain: RTL and testbench

- Receives the skewed 34-bit partial-sum outputs from the bottom edge of the systolic array.
- Column j's result for a given row arrives j cycles after column 0's result for that row.
- The block delays each column so that the whole row lines up, then stores aligned rows in a small row FIFO.
- It then sends the row out one word at a time over a valid/ready stream to the result writeback path.
- It is the read-out end of the array's skewed register pipeline.

---
 rtl/psum_deskew_drain.sv | 119 +++++++++++
 tb/tb_psum_deskew_drain.sv | 216 +++++++++++++++++++++
 2 files changed

// File: rtl/psum_deskew_drain.sv
// Deskews the staggered partial-sum columns from the array's bottom edge, queues
// complete rows in a small FIFO, and drains each row one word at a time.
module psum_deskew_drain #(
  parameter int W     = 34,
  parameter int COLS  = 4,
  parameter int DEPTH = 4
) (
  input  logic                     C,
  input  logic                     R,
  input  logic [COLS-1:0]          col_valid,
  input  logic [COLS*W-1:0]        col_data,
  output logic                     in_ready,
  output logic                     out_valid,
  output logic [W-1:0]             out_data,
  output logic                     out_last,
  input  logic                     out_ready,
  output logic [$clog2(DEPTH):0]   fifo_count,
  output logic                     skew_err,
  output logic                     overflow
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int IW = $clog2(COLS);
  localparam logic [IW-1:0] LAST_IDX = IW'(COLS - 1);
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  logic [COLS-1:0]   vld_al;
  logic [COLS*W-1:0] dat_al;
  logic [COLS-2:0]   c0_vld;

  // Column j is delayed COLS-1-j cycles so every column of a row lines up.
  genvar j;
  generate
    for (j = 0; j < COLS; j++) begin : g_col
      localparam int D = COLS - 1 - j;
      if (D == 0) begin : g_pass
        assign vld_al[j]         = col_valid[j];
        assign dat_al[j*W +: W]  = col_data[j*W +: W];
      end else begin : g_dly
        logic [D-1:0] vld_p;
        logic [W-1:0] dat_p [D];
        always_ff @(posedge C or posedge R) begin
          if (R) begin
            vld_p <= '0;
            for (int k = 0; k < D; k++) dat_p[k] <= '0;
          end else begin
            vld_p[0] <= col_valid[j];
            dat_p[0] <= col_data[j*W +: W];
            for (int k = 1; k < D; k++) begin
              vld_p[k] <= vld_p[k-1];
              dat_p[k] <= dat_p[k-1];
            end
          end
        end
        assign vld_al[j]        = vld_p[D-1];
        assign dat_al[j*W +: W] = dat_p[D-1];
        if (j == 0) begin : g_c0
          assign c0_vld = vld_p;
        end
      end
    end
  endgenerate

  logic              aligned_any, aligned_all;
  logic [COLS*W-1:0] mem [DEPTH];
  logic [COLS*W-1:0] head_row;
  logic [PW-1:0]     head, tail;
  logic [IW-1:0]     idx;
  logic              full, pop, push;
  logic [CW:0]       inflight, occupancy;

  assign aligned_any = |vld_al;
  assign aligned_all = &vld_al;
  assign full        = (fifo_count == FULL_CNT);
  assign out_valid   = (fifo_count != '0);
  assign pop         = out_valid & out_ready & (idx == LAST_IDX);
  // A pop on the same edge frees the slot, so a write at full still lands.
  assign push        = aligned_all & (~full | pop);

  always_comb begin
    inflight = '0;
    for (int k = 0; k < COLS - 1; k++) inflight = inflight + (CW+1)'(c0_vld[k]);
    occupancy = {1'b0, fifo_count} + inflight;
    in_ready  = (occupancy < (CW+1)'(DEPTH));
  end

  assign head_row = mem[head];
  assign out_data = out_valid ? head_row[idx*W +: W] : '0;
  assign out_last = out_valid & (idx == LAST_IDX);

  // Row storage carries no reset; emptiness is tracked by fifo_count alone.
  always_ff @(posedge C) begin
    if (push) mem[tail] <= dat_al;
  end

  always_ff @(posedge C or posedge R) begin
    if (R) begin
      head       <= '0;
      tail       <= '0;
      idx        <= '0;
      fifo_count <= '0;
      skew_err   <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      if (push) tail <= tail + PW'(1);
      if (pop)  head <= head + PW'(1);
      if (out_valid && out_ready) idx <= (idx == LAST_IDX) ? '0 : idx + IW'(1);
      case ({push, pop})
        2'b10:   fifo_count <= fifo_count + CW'(1);
        2'b01:   fifo_count <= fifo_count - CW'(1);
        default: fifo_count <= fifo_count;
      endcase
      if (aligned_any && !aligned_all) skew_err <= 1'b1;
      if (aligned_all && full && !pop) overflow <= 1'b1;
    end
  end

endmodule

// File: tb/tb_psum_deskew_drain.sv
// Randomized bench for psum_deskew_drain against a row-level queue model.
module tb_psum_deskew_drain;

  localparam int W     = 34;
  localparam int COLS  = 4;
  localparam int DEPTH = 4;
  localparam int NC    = 4096;

  typedef logic [COLS*W-1:0] row_t;

  logic                   C = 1'b0;
  logic                   R = 1'b0;
  logic [COLS-1:0]        col_valid = '0;
  logic [COLS*W-1:0]      col_data = '0;
  logic                   in_ready;
  logic                   out_valid;
  logic [W-1:0]           out_data;
  logic                   out_last;
  logic                   out_ready = 1'b0;
  logic [$clog2(DEPTH):0] fifo_count;
  logic                   skew_err;
  logic                   overflow;

  always #5 C = ~C;

  psum_deskew_drain #(.W(W), .COLS(COLS), .DEPTH(DEPTH)) dut (
    .C(C), .R(R), .col_valid(col_valid), .col_data(col_data),
    .in_ready(in_ready), .out_valid(out_valid), .out_data(out_data),
    .out_last(out_last), .out_ready(out_ready), .fifo_count(fifo_count),
    .skew_err(skew_err), .overflow(overflow)
  );

  // Model: queue of whole rows, word index into head row, sticky flags,
  // and a per-cycle schedule of issued rows (with any withheld columns).
  row_t            q[$];
  int              m_idx;
  bit              m_skew, m_ovf;
  bit              iss   [NC];
  logic [COLS-1:0] dmask [NC];
  row_t            rdat  [NC];
  int              cyc;
  int              n_chk, n_err;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  function automatic int inflight();
    int n = 0;
    for (int k = 1; k < COLS; k++)
      if (cyc - k >= 0 && iss[cyc-k] && !dmask[cyc-k][0]) n++;
    return n;
  endfunction

  function automatic row_t rnd_row();
    row_t r;
    for (int k = 0; k < COLS; k++) r[k*W +: W] = W'({$urandom(), $urandom()});
    return r;
  endfunction

  task automatic cycle(input bit want, input bit force_i, input logic [COLS-1:0] drop,
                       input logic ordy, input row_t dat);
    bit         rdy_m, issue, ov, pop, comp;
    row_t       hd;
    logic [W-1:0] exp_d;
    int         r;
    rdy_m = (q.size() + inflight()) < DEPTH;
    issue = want && (rdy_m || force_i);
    iss[cyc]   = issue;
    dmask[cyc] = drop;
    rdat[cyc]  = dat;
    for (int j = 0; j < COLS; j++) begin
      r = cyc - j;
      if (r >= 0 && iss[r] && !dmask[r][j]) begin
        hd = rdat[r];
        col_valid[j]         = 1'b1;
        col_data[j*W +: W]   = hd[j*W +: W];
      end else begin
        col_valid[j]         = 1'b0;
        col_data[j*W +: W]   = '0;
      end
    end
    out_ready = ordy;
    #1;
    ov = (q.size() != 0);
    exp_d = '0;
    if (ov) begin
      hd = q[0];
      exp_d = hd[m_idx*W +: W];
    end
    chk("out_valid",  out_valid,  ov);
    chk("out_data",   out_data,   exp_d);
    chk("out_last",   out_last,   ov && (m_idx == COLS-1));
    chk("fifo_count", fifo_count, q.size());
    chk("in_ready",   in_ready,   rdy_m);
    chk("skew_err",   skew_err,   m_skew);
    chk("overflow",   overflow,   m_ovf);
    pop = ov && ordy && (m_idx == COLS-1);
    if (ov && ordy) m_idx = pop ? 0 : m_idx + 1;
    r = cyc - (COLS - 1);
    comp = 1'b0;
    if (r >= 0 && iss[r]) begin
      if (dmask[r] == '0) comp = 1'b1;
      else if (dmask[r] != '1) m_skew = 1'b1;
    end
    if (pop) void'(q.pop_front());
    if (comp) begin
      if (q.size() < DEPTH) q.push_back(rdat[r]);
      else m_ovf = 1'b1;
    end
    @(posedge C);
    #1;
    cyc++;
  endtask

  task automatic do_reset();
    R = 1'b1;
    col_valid = '0;
    col_data  = '0;
    #1;
    chk("rst_out_valid",  out_valid,  0);
    chk("rst_out_data",   out_data,   0);
    chk("rst_out_last",   out_last,   0);
    chk("rst_fifo_count", fifo_count, 0);
    chk("rst_in_ready",   in_ready,   1);
    chk("rst_skew_err",   skew_err,   0);
    chk("rst_overflow",   overflow,   0);
    @(posedge C);
    #1;
    R = 1'b0;
    q.delete();
    m_idx = 0;
    m_skew = 1'b0;
    m_ovf = 1'b0;
    for (int k = 0; k < NC; k++) iss[k] = 1'b0;
    cyc++;
  endtask

  task automatic rnd_phase(input int n, input bit with_drops);
    logic [COLS-1:0] drop;
    for (int i = 0; i < n; i++) begin
      drop = '0;
      if (with_drops && $urandom_range(0, 19) == 0)
        drop = COLS'($urandom_range(1, (1 << COLS) - 2));
      cycle($urandom_range(0, 2) != 0, $urandom_range(0, 9) == 0, drop,
            $urandom_range(0, 3) != 0, rnd_row());
    end
  endtask

  row_t d1;

  initial begin
    n_chk = 0;
    n_err = 0;
    cyc = 0;
    d1 = {34'd4, 34'd3, 34'd2, 34'd1};
    #2;
    do_reset();

    // Single row, consumer always ready.
    cycle(1, 0, '0, 1, d1);
    repeat (10) cycle(0, 0, '0, 1, '0);
    do_reset();

    // One stored row stalled by back-pressure, then drained.
    cycle(1, 0, '0, 0, d1);
    repeat (9) cycle(0, 0, '0, 0, '0);
    repeat (8) cycle(0, 0, '0, 1, '0);
    do_reset();

    // Fill honouring in_ready, then force a fifth row into a full FIFO.
    repeat (10) cycle(1, 0, '0, 0, rnd_row());
    cycle(1, 1, '0, 0, rnd_row());
    repeat (5) cycle(0, 0, '0, 0, '0);
    repeat (20) cycle(0, 0, '0, 1, '0);
    do_reset();

    // Full FIFO: forced row written on the same edge the head row pops.
    repeat (10) cycle(1, 0, '0, 0, rnd_row());
    cycle(1, 1, '0, 1, rnd_row());
    repeat (3) cycle(0, 0, '0, 1, '0);
    repeat (3) cycle(0, 0, '0, 0, '0);
    repeat (20) cycle(0, 0, '0, 1, '0);
    do_reset();

    // Row with column 2 withheld, then a well-formed row.
    cycle(1, 0, 4'b0100, 1, rnd_row());
    repeat (5) cycle(0, 0, '0, 1, '0);
    cycle(1, 0, '0, 1, rnd_row());
    repeat (8) cycle(0, 0, '0, 1, '0);
    do_reset();

    rnd_phase(300, 1'b0);
    do_reset();
    rnd_phase(300, 1'b1);
    do_reset();

    // Reset in the middle of a row while rows are stored.
    cycle(1, 0, '0, 0, rnd_row());
    cycle(1, 0, '0, 0, rnd_row());
    cycle(0, 0, '0, 0, '0);
    cycle(0, 0, '0, 0, '0);
    cycle(1, 0, '0, 0, rnd_row());
    cycle(0, 0, '0, 0, '0);
    do_reset();
    repeat (10) cycle(0, 0, '0, 1, '0);

    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end

endmodule
